// File: rtl/lr35902_irq_pkg.sv
// Shared constants and helpers for the LR35902 interrupt controller.
package lr35902_irq_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IRQ_COUNT = 5;
  localparam int unsigned IRQ_ID_W  = 3;

  // IF/IE bit positions, bit0 is the highest priority
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  // Register select values on adr
  localparam logic ADR_IF = 1'b0;
  localparam logic ADR_IE = 1'b1;

  typedef logic [IRQ_COUNT-1:0] irq_vec_t;

  // Register write payload as seen on the bus in the commit cycle
  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  // CPU dispatch vector for an interrupt id: 0x40 + 8*id
  function automatic logic [DATA_W-1:0] irq_vector(input logic [IRQ_ID_W-1:0] id);
    return 8'h40 + {2'b00, id, 3'b000};
  endfunction

endpackage

// File: rtl/lr35902_irq_prio.sv
// Fixed 5-input priority encoder: lowest set bit wins.
module lr35902_irq_prio
  import lr35902_irq_pkg::*;
(
  input  logic [IRQ_COUNT-1:0] req_i,
  output logic                 any_o,
  output logic [IRQ_ID_W-1:0]  idx_o
);

  // Scan from the lowest priority down so the lowest set index is left last
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = int'(IRQ_COUNT) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/lr35902_irq_ctrl.sv
// LR35902 interrupt controller: IF (FF0F) / IE (FFFF) registers, request
// capture, priority selection and acknowledge clearing.
// Build option: define LR35902_IRQ_EDGE_EN for rising-edge request capture;
// otherwise requests are level-sensitive and no edge history is kept.
module lr35902_irq_ctrl
  import lr35902_irq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic [DATA_W-1:0]   dout,
  input  logic [DATA_W-1:0]   din,
  input  logic                adr,
  input  logic                read,
  input  logic                write,
  input  logic [IRQ_COUNT-1:0] irq_in,
  input  logic                int_ack,
  output logic                int_pending,
  output logic [IRQ_ID_W-1:0] int_id
);

  irq_vec_t          if_q, if_d;
  logic [DATA_W-1:0] ie_q, ie_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              pread_q, pwrite_q;

  irq_vec_t          set_vec;
  irq_vec_t          active;
  irq_vec_t          ack_mask;
  logic              any_pending;
  logic [IRQ_ID_W-1:0] pend_id;
  logic              wr_commit;
  logic              rd_start;
  logic              ack_take;
  reg_wr_t           wr_bus;

  // Strobe qualification: writes land on the falling edge of write,
  // reads capture on the rising edge of read
  assign wr_commit   = pwrite_q & ~write;
  assign rd_start    = read & ~pread_q;
  assign wr_bus.sel  = adr;
  assign wr_bus.data = din;

`ifdef LR35902_IRQ_EDGE_EN
  irq_vec_t irq_prev_q;

  // Edge history of the request lines
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
    end else begin
      irq_prev_q <= irq_in;
    end
  end

  assign set_vec = irq_in & ~irq_prev_q;
`else
  assign set_vec = irq_in;
`endif

  // Only IE[4:0] participate; IE[7:5] are storage only
  assign active = if_q & ie_q[IRQ_COUNT-1:0];

  lr35902_irq_prio u_prio (
    .req_i (active),
    .any_o (any_pending),
    .idx_o (pend_id)
  );

  assign int_pending = any_pending;
  assign int_id      = pend_id;
  assign ack_take    = int_ack & any_pending;
  assign ack_mask    = ack_take ? (IRQ_COUNT'(1) << pend_id) : '0;
  assign dout        = dout_q;

  // Next IF: write first, then ack clear, then new requests so they always survive
  always_comb begin
    if_d = if_q;
    if (wr_commit && (wr_bus.sel == ADR_IF)) begin
      if_d = wr_bus.data[IRQ_COUNT-1:0];
    end
    if_d = if_d & ~ack_mask;
    if_d = if_d | set_vec;
  end

  // Next IE: full 8-bit register
  always_comb begin
    ie_d = ie_q;
    if (wr_commit && (wr_bus.sel == ADR_IE)) begin
      ie_d = wr_bus.data;
    end
  end

  // Read data capture; IF upper bits read back as ones
  always_comb begin
    dout_d = dout_q;
    if (rd_start) begin
      if (adr == ADR_IE) begin
        dout_d = ie_q;
      end else begin
        dout_d = {{(DATA_W - IRQ_COUNT){1'b1}}, if_q};
      end
    end
  end

  // Register state with synchronous reset taking precedence over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q     <= '0;
      ie_q     <= '0;
      dout_q   <= 8'hff;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
    end else begin
      if_q     <= if_d;
      ie_q     <= ie_d;
      dout_q   <= dout_d;
      pread_q  <= read;
      pwrite_q <= write;
    end
  end

endmodule

// File: tb/tb_lr35902_irq_ctrl.sv
// Self-checking bench for lr35902_irq_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the IF/IE rules.
module tb_lr35902_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dout;
  logic [7:0] din;
  logic       adr;
  logic       read;
  logic       write;
  logic [4:0] irq_in;
  logic       int_ack;
  logic       int_pending;
  logic [2:0] int_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_if, m_ie, m_dout, m_prev;
  bit m_pr, m_pw;

  lr35902_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .dout        (dout),
    .din         (din),
    .adr         (adr),
    .read        (read),
    .write       (write),
    .irq_in      (irq_in),
    .int_ack     (int_ack),
    .int_pending (int_pending),
    .int_id      (int_id)
  );

  always #5 clk = ~clk;

  function automatic int m_active();
    return m_if & m_ie & 31;
  endfunction

  function automatic int m_id();
    int a;
    a = m_active();
    for (int i = 0; i < 5; i++) begin
      if (((a >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  // Advance one clock: model computes the next state from the inputs of this cycle
  task automatic cycle();
    int set, nif, nie, ndout, nprev;
    bit npr, npw;
    if (reset) begin
      nif = 0; nie = 0; ndout = 255; nprev = 0; npr = 0; npw = 0;
    end else begin
`ifdef LR35902_IRQ_EDGE_EN
      set = int'(irq_in) & ~m_prev & 31;
`else
      set = int'(irq_in);
`endif
      nif = m_if;
      if (m_pw && !write && adr == 1'b0) nif = int'(din) & 31;
      if (int_ack && m_active() != 0) nif = nif & ~(1 << m_id());
      nif = nif | set;
      nie = (m_pw && !write && adr == 1'b1) ? int'(din) : m_ie;
      if (read && !m_pr) ndout = adr ? m_ie : (224 | m_if);
      else ndout = m_dout;
      nprev = int'(irq_in);
      npr = read;
      npw = write;
    end
    @(posedge clk);
    #1;
    m_if = nif; m_ie = nie; m_dout = ndout; m_prev = nprev; m_pr = npr; m_pw = npw;
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    adr = a; read = 1'b1;
    cycle();
    d = dout;
    read = 1'b0;
    cycle();
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    adr = a; din = v; write = 1'b1;
    cycle();
    write = 1'b0;
    cycle();
  endtask

  task automatic pulse(input logic [4:0] m);
    irq_in = m;
    cycle();
    irq_in = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    cycle(); cycle();
    checks++;
    if (dout !== 8'hff) begin errors++; $display("FAIL reset_dout: got %h want ff", dout); end
    reset = 1'b0;
    checks++;
    if (int_pending !== 1'b0 || int_id !== 3'd0) begin
      errors++; $display("FAIL reset_pending: got %b/%0d want 0/0", int_pending, int_id);
    end
    rd(1'b0, d);
    checks++;
    if (d !== 8'he0) begin errors++; $display("FAIL reset_if: got %h want e0", d); end
    rd(1'b1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h want 00", d); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    wr(1'b1, 8'h08);
    pulse(5'b01000);
    checks++;
    if (int_pending !== 1'b1 || int_id !== 3'd3) begin
      errors++; $display("FAIL serial_pend: got %b/%0d want 1/3", int_pending, int_id);
    end
    rd(1'b0, d);
    checks++;
    if (d !== 8'he8) begin errors++; $display("FAIL serial_if: got %h want e8", d); end
    ack();
    checks++;
    if (int_pending !== 1'b0) begin errors++; $display("FAIL serial_ack_pend: got %b want 0", int_pending); end
    rd(1'b0, d);
    checks++;
    if (d !== 8'he0) begin errors++; $display("FAIL serial_ack_if: got %h want e0", d); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr(1'b1, 8'h1f);
    pulse(5'b00101);
    checks++;
    if (int_pending !== 1'b1 || int_id !== 3'd0) begin
      errors++; $display("FAIL prio_first: got %b/%0d want 1/0", int_pending, int_id);
    end
    ack();
    checks++;
    if (int_id !== 3'd2) begin errors++; $display("FAIL prio_second: got %0d want 2", int_id); end
    rd(1'b0, d);
    checks++;
    if (d !== 8'he4) begin errors++; $display("FAIL prio_if: got %h want e4", d); end
    ack();
    checks++;
    if (int_pending !== 1'b0) begin errors++; $display("FAIL prio_done: got %b want 0", int_pending); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    pulse(5'b00100);
    adr = 1'b0; din = 8'h00; write = 1'b1;
    cycle();
    write = 1'b0; irq_in = 5'b00100;
    cycle();
    irq_in = '0;
    rd(1'b0, d);
    checks++;
    if (d !== 8'he4) begin errors++; $display("FAIL wr_vs_set: got %h want e4", d); end
    int_ack = 1'b1; irq_in = 5'b00100;
    cycle();
    int_ack = 1'b0; irq_in = '0;
    rd(1'b0, d);
    checks++;
    if (d !== 8'he4) begin errors++; $display("FAIL ack_vs_set: got %h want e4", d); end
    ack();
    rd(1'b0, d);
    checks++;
    if (d !== 8'he0) begin errors++; $display("FAIL ack_plain: got %h want e0", d); end
  endtask

  task automatic test_masked();
    logic [7:0] d;
    wr(1'b1, 8'h00);
    pulse(5'b10000);
    rd(1'b0, d);
    checks++;
    if (d !== 8'hf0) begin errors++; $display("FAIL masked_if: got %h want f0", d); end
    checks++;
    if (int_pending !== 1'b0) begin errors++; $display("FAIL masked_pend: got %b want 0", int_pending); end
    wr(1'b1, 8'h10);
    checks++;
    if (int_pending !== 1'b1 || int_id !== 3'd4) begin
      errors++; $display("FAIL unmask: got %b/%0d want 1/4", int_pending, int_id);
    end
    ack();
  endtask

  task automatic test_held();
    logic [7:0] d;
    logic exp_p;
`ifdef LR35902_IRQ_EDGE_EN
    exp_p = 1'b0;
`else
    exp_p = 1'b1;
`endif
    wr(1'b1, 8'h02);
    wr(1'b0, 8'h00);
    irq_in = 5'b00010;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (int_pending !== 1'b1 || int_id !== 3'd1) begin
      errors++; $display("FAIL held_pend: got %b/%0d want 1/1", int_pending, int_id);
    end
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    cycle(); cycle();
    checks++;
    if (int_pending !== exp_p) begin errors++; $display("FAIL held_after_ack: got %b want %b", int_pending, exp_p); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rd(1'b0, d);
    checks++;
    if (d !== 8'he0) begin errors++; $display("FAIL held_reset_if: got %h want e0", d); end
    wr(1'b0, 8'h00);
    rd(1'b0, d);
    checks++;
    if (d !== (exp_p ? 8'he2 : 8'he0)) begin
      errors++; $display("FAIL held_after_reset: got %h want %h", d, exp_p ? 8'he2 : 8'he0);
    end
    irq_in = '0;
    cycle();
    pulse(5'b00010);
    rd(1'b0, d);
    checks++;
    if (d !== 8'he2) begin errors++; $display("FAIL held_new_edge: got %h want e2", d); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      read    = ($urandom_range(0, 3) == 0);
      write   = ($urandom_range(0, 2) == 0);
      adr     = 1'($urandom_range(0, 1));
      din     = 8'($urandom);
      irq_in  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      int_ack = ($urandom_range(0, 3) == 0);
      cycle();
      checks++;
      if (int_pending !== (m_active() != 0) || int_id !== 3'(m_id())) begin
        errors++;
        $display("FAIL rand_irq[%0d]: got %b/%0d want %b/%0d", n, int_pending, int_id, m_active() != 0, m_id());
      end
      checks++;
      if (dout !== 8'(m_dout)) begin
        errors++; $display("FAIL rand_dout[%0d]: got %h want %h", n, dout, 8'(m_dout));
      end
    end
    reset = 1'b0; read = 1'b0; write = 1'b0; int_ack = 1'b0; irq_in = '0;
    cycle();
  endtask

  initial begin
    reset = 1'b1; din = '0; adr = 1'b0; read = 1'b0; write = 1'b0;
    irq_in = '0; int_ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_same_cycle();
    test_masked();
    test_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
